mem_stage_ctrl: RTL and testbench

Memory-stage controller for the pipelined LC-3b datapath. Sits between the EX/MEM pipeline buffer and the MEM/WB pipeline buffer, and consumes the buffered instruction, MAR and MDR values. It performs LDB/LDW/LDI/STB/STW/STI accesses on the data-cache port using a request/response handshake, including the two-access indirect sequence. While an access is in flight it stalls the upstream buffers, and it presents load data for writeback.

---
 rtl/mem_stage_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : LC-3b memory-stage controller. Issues LDB/LDW/LDI/STB/STW/STI
//            accesses on the data-cache handshake and stalls the pipeline.
//            Optional macro MEM_ALIGN_CHECK_EN enables misaligned-word faults.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [3:0]  opcode,
  input  logic [15:0] mar_in,
  input  logic [15:0] mdr_in,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic [15:0] result_out,
  output logic        result_valid,
  output logic        align_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IND  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_op;
  logic [15:0] r_mdr;

  logic [3:0]  w_sel_op;
  logic [15:0] w_sel_addr;
  logic [15:0] w_sel_mdr;
  logic        w_mem_op;
  logic        w_byte;
  logic        w_ind;
  logic        w_load;
  logic        w_accept;
  logic        w_misaligned;
  logic [15:0] w_addr;
  logic [15:0] w_wdata;
  logic [1:0]  w_be;
  logic [7:0]  w_rbyte;
  logic [15:0] w_load_data;

  // Next request is built from live inputs in IDLE, and from the latched
  // operands plus the returned pointer when leaving IND.
  assign w_sel_op   = (r_state == S_IDLE) ? opcode : r_op;
  assign w_sel_addr = (r_state == S_IND)  ? dmem_rdata : mar_in;
  assign w_sel_mdr  = (r_state == S_IDLE) ? mdr_in : r_mdr;

  assign w_mem_op = w_sel_op[1] & ~(w_sel_op[3] & w_sel_op[2]);
  assign w_byte   = (w_sel_op[3:2] == 2'b00);
  assign w_ind    = (w_sel_op[3:2] == 2'b10);
  assign w_load   = ~w_sel_op[0];
  assign w_accept = (r_state == S_IDLE) & valid_in & w_mem_op;

  assign w_be    = w_byte ? (w_sel_addr[0] ? 2'b10 : 2'b01) : 2'b11;
  assign w_wdata = w_byte ? {w_sel_mdr[7:0], w_sel_mdr[7:0]} : w_sel_mdr;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_align_fault;

  assign w_misaligned = ~w_byte & w_sel_addr[0];
  assign w_addr       = w_sel_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_align_fault <= 1'b0;
    end else begin
      r_align_fault <= w_misaligned &
                       (w_accept | ((r_state == S_IND) & dmem_resp));
    end
  end

  assign align_fault = r_align_fault;
`else
  assign w_misaligned = 1'b0;
  assign w_addr       = w_byte ? w_sel_addr : {w_sel_addr[15:1], 1'b0};
  assign align_fault  = 1'b0;
`endif

  // Byte lane for LDB follows the address bit held on the request bus.
  assign w_rbyte     = dmem_address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
  assign w_load_data = w_byte ? {{8{w_rbyte[7]}}, w_rbyte} : dmem_rdata;

  assign mem_stall = reset_n &
                     (w_accept | (r_state == S_IND) | (r_state == S_DATA));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_op             <= 4'h0;
      r_mdr            <= 16'h0000;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= 16'h0000;
      dmem_wdata       <= 16'h0000;
      dmem_byte_enable <= 2'b00;
      result_out       <= 16'h0000;
      result_valid     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op             <= opcode;
            r_mdr            <= mdr_in;
            dmem_address     <= w_addr;
            dmem_wdata       <= w_wdata;
            dmem_byte_enable <= w_be;
            if (w_misaligned) begin
              r_state <= S_DONE;
            end else if (w_ind) begin
              r_state   <= S_IND;
              dmem_read <= 1'b1;
            end else begin
              r_state    <= S_DATA;
              dmem_read  <= w_load;
              dmem_write <= ~w_load;
            end
          end
        end
        S_IND: begin
          if (dmem_resp) begin
            dmem_read        <= 1'b0;
            dmem_address     <= w_addr;
            dmem_wdata       <= w_wdata;
            dmem_byte_enable <= w_be;
            if (w_misaligned) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_DATA;
              dmem_read  <= w_load;
              dmem_write <= ~w_load;
            end
          end
        end
        S_DATA: begin
          if (dmem_resp) begin
            r_state    <= S_DONE;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (w_load) begin
              result_out   <= w_load_data;
              result_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Brief    : Directed self-checking bench for mem_stage_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [3:0]  opcode;
  logic [15:0] mar_in;
  logic [15:0] mdr_in;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic        mem_stall;
  logic [15:0] result_out;
  logic        result_valid;
  logic        align_fault;

  int n_checks = 0;
  int n_pass   = 0;
  int stall;
  int hold;

  mem_stage_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_in         (valid_in),
    .opcode           (opcode),
    .mar_in           (mar_in),
    .mdr_in           (mdr_in),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .mem_stall        (mem_stall),
    .result_out       (result_out),
    .result_valid     (result_valid),
    .align_fault      (align_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] mar,
                       input logic [15:0] mdr);
    valid_in = 1'b1;
    opcode   = op;
    mar_in   = mar;
    mdr_in   = mdr;
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    valid_in   = 1'b0;
    opcode     = 4'h0;
    mar_in     = 16'h0000;
    mdr_in     = 16'h0000;
    dmem_rdata = 16'h0000;
    dmem_resp  = 1'b0;
    #1;
    check("rst_read",   {15'd0, dmem_read}, 16'd0);
    check("rst_write",  {15'd0, dmem_write}, 16'd0);
    check("rst_addr",   dmem_address, 16'h0000);
    check("rst_be",     {14'd0, dmem_byte_enable}, 16'd0);
    check("rst_result", result_out, 16'h0000);
    check("rst_valid",  {15'd0, result_valid}, 16'd0);
    tick;
    tick;
    reset_n = 1'b1;
    tick;

    // Non-memory opcode passes straight through
    issue(4'b0001, 16'h1111, 16'h2222);
    check("nop_stall", {15'd0, mem_stall}, 16'd0);
    tick;
    check("nop_read",  {15'd0, dmem_read}, 16'd0);
    check("nop_write", {15'd0, dmem_write}, 16'd0);
    valid_in = 1'b0;
    opcode   = 4'b0110;
    #1;
    check("novalid_stall", {15'd0, mem_stall}, 16'd0);

    // LDW, response on first request cycle
    issue(4'b0110, 16'h1234, 16'h0000);
    stall = 0;
    stall += int'(mem_stall);
    tick;
    valid_in = 1'b0;
    stall += int'(mem_stall);
    check("ldw_read", {15'd0, dmem_read}, 16'd1);
    check("ldw_addr", dmem_address, 16'h1234);
    check("ldw_be",   {14'd0, dmem_byte_enable}, 16'd3);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'hBEEF;
    tick;
    dmem_resp = 1'b0;
    stall += int'(mem_stall);
    check("ldw_valid",  {15'd0, result_valid}, 16'd1);
    check("ldw_result", result_out, 16'hBEEF);
    check("ldw_read_done", {15'd0, dmem_read}, 16'd0);
    check("ldw_stall_cycles", 16'(stall), 16'd2);
    tick;
    check("ldw_valid_drop", {15'd0, result_valid}, 16'd0);
    check("ldw_result_hold", result_out, 16'hBEEF);

    // LDB at odd address, three wait cycles
    issue(4'b0010, 16'h2001, 16'h0000);
    tick;
    valid_in = 1'b0;
    dmem_rdata = 16'h80FF;
    hold = 0;
    for (int i = 0; i < 3; i++) begin
      hold += int'(dmem_read);
      check("ldb_wait_valid", {15'd0, result_valid}, 16'd0);
      tick;
    end
    hold += int'(dmem_read);
    check("ldb_addr", dmem_address, 16'h2001);
    check("ldb_be",   {14'd0, dmem_byte_enable}, 16'd2);
    check("ldb_hold_cycles", 16'(hold), 16'd4);
    dmem_resp = 1'b1;
    tick;
    dmem_resp = 1'b0;
    check("ldb_valid",  {15'd0, result_valid}, 16'd1);
    check("ldb_result", result_out, 16'hFF80);
    tick;

    // STB at even address
    issue(4'b0011, 16'h3000, 16'h12AB);
    tick;
    valid_in = 1'b0;
    check("stb_write", {15'd0, dmem_write}, 16'd1);
    check("stb_read",  {15'd0, dmem_read}, 16'd0);
    check("stb_wdata", dmem_wdata, 16'hABAB);
    check("stb_be",    {14'd0, dmem_byte_enable}, 16'd1);
    check("stb_addr",  dmem_address, 16'h3000);
    dmem_resp = 1'b1;
    tick;
    dmem_resp = 1'b0;
    check("stb_valid",       {15'd0, result_valid}, 16'd0);
    check("stb_result_hold", result_out, 16'hFF80);
    check("stb_write_done",  {15'd0, dmem_write}, 16'd0);
    tick;

    // LDI: pointer fetch then data fetch
    issue(4'b1010, 16'h4000, 16'h0000);
    stall = 0;
    stall += int'(mem_stall);
    tick;
    valid_in = 1'b0;
    stall += int'(mem_stall);
    check("ldi_ind_read", {15'd0, dmem_read}, 16'd1);
    check("ldi_ind_addr", dmem_address, 16'h4000);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h5000;
    tick;
    stall += int'(mem_stall);
    check("ldi_data_read", {15'd0, dmem_read}, 16'd1);
    check("ldi_data_addr", dmem_address, 16'h5000);
    check("ldi_mid_valid", {15'd0, result_valid}, 16'd0);
    dmem_rdata = 16'h0042;
    tick;
    dmem_resp = 1'b0;
    stall += int'(mem_stall);
    check("ldi_valid",  {15'd0, result_valid}, 16'd1);
    check("ldi_result", result_out, 16'h0042);
    check("ldi_stall_cycles", 16'(stall), 16'd3);
    tick;

    // Reset asserted mid-access
    issue(4'b0110, 16'h0AAA, 16'h0000);
    tick;
    valid_in = 1'b0;
    check("rstmid_read_before", {15'd0, dmem_read}, 16'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_read",  {15'd0, dmem_read}, 16'd0);
    check("rstmid_stall", {15'd0, mem_stall}, 16'd0);
    #2;
    reset_n = 1'b1;
    tick;
    check("rstmid_valid0", {15'd0, result_valid}, 16'd0);
    check("rstmid_read_idle", {15'd0, dmem_read}, 16'd0);
    tick;
    check("rstmid_valid1", {15'd0, result_valid}, 16'd0);

    // STW at odd address
    issue(4'b0111, 16'h0101, 16'h5A5A);
    tick;
    valid_in = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    check("stw_odd_write", {15'd0, dmem_write}, 16'd0);
    check("stw_odd_fault", {15'd0, align_fault}, 16'd1);
    check("stw_odd_stall", {15'd0, mem_stall}, 16'd0);
    tick;
    check("stw_odd_fault_drop", {15'd0, align_fault}, 16'd0);
`else
    check("stw_odd_write", {15'd0, dmem_write}, 16'd1);
    check("stw_odd_addr",  dmem_address, 16'h0100);
    check("stw_odd_wdata", dmem_wdata, 16'h5A5A);
    check("stw_odd_fault", {15'd0, align_fault}, 16'd0);
    dmem_resp = 1'b1;
    tick;
    dmem_resp = 1'b0;
    check("stw_odd_done_valid", {15'd0, result_valid}, 16'd0);
    tick;
`endif
    check("end_read", {15'd0, dmem_read}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
